// File: rtl/bist_controller.sv
// BIST session sequencer: seeds TPG/MISR, applies N_PATTERNS, flushes CUT latency,
// freezes the MISR and checks its signature against GOLDEN.
module bist_controller #(
    parameter int unsigned           N_PATTERNS   = 1000,
    parameter int unsigned           CNT_W        = 16,
    parameter int unsigned           FLUSH_CYCLES = 2,
    parameter int unsigned           SIG_W        = 15,
    parameter logic [SIG_W-1:0]      GOLDEN       = 15'h5B6F
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             abort,
    input  logic [SIG_W-1:0] misr_sig,
    output logic             tpg_rst,
    output logic             tpg_en,
    output logic             misr_rst,
    output logic             bist_end,
    output logic             bist_mode,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [CNT_W-1:0] pattern_cnt
);

    localparam int unsigned FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_PATTERNS - 1);
    localparam logic [FL_W-1:0]  FL_LAST  = FL_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RUN,
        FLUSH,
        COMPARE,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              init_ph;
    logic [FL_W-1:0]   flush_cnt;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state       <= IDLE;
            pattern_cnt <= '0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            init_ph     <= 1'b0;
            flush_cnt   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE, DONE: begin
                    if (state_next == INIT) begin
                        pattern_cnt <= '0;
                        pass        <= 1'b0;
                        fail        <= 1'b0;
                        init_ph     <= 1'b0;
                    end
                end
                INIT: begin
                    init_ph <= ~init_ph;
                    if (state_next == IDLE) begin
                        pass <= 1'b0;
                        fail <= 1'b0;
                    end
                end
                RUN: begin
                    // The pattern applied this cycle counts even when aborting at its edge.
                    pattern_cnt <= pattern_cnt + CNT_W'(1);
                    flush_cnt   <= '0;
                    if (state_next == IDLE) begin
                        pass <= 1'b0;
                        fail <= 1'b0;
                    end
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt + FL_W'(1);
                    if (state_next == IDLE) begin
                        pass <= 1'b0;
                        fail <= 1'b0;
                    end
                end
                COMPARE: begin
                    pass <= (misr_sig == GOLDEN);
                    fail <= (misr_sig != GOLDEN);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        tpg_rst    = 1'b0;
        tpg_en     = 1'b0;
        misr_rst   = 1'b0;
        bist_end   = 1'b1;
        bist_mode  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = INIT;
            end
            INIT: begin
                tpg_rst   = 1'b1;
                misr_rst  = 1'b1;
                bist_mode = 1'b1;
                busy      = 1'b1;
                if (abort)        state_next = IDLE;
                else if (init_ph) state_next = RUN;
            end
            RUN: begin
                tpg_en    = 1'b1;
                bist_end  = 1'b0;
                bist_mode = 1'b1;
                busy      = 1'b1;
                if (abort)
                    state_next = IDLE;
                else if (pattern_cnt == CNT_LAST)
                    state_next = (FLUSH_CYCLES == 0) ? COMPARE : FLUSH;
            end
            FLUSH: begin
                bist_end  = 1'b0;
                bist_mode = 1'b1;
                busy      = 1'b1;
                if (abort)                     state_next = IDLE;
                else if (flush_cnt == FL_LAST) state_next = COMPARE;
            end
            COMPARE: begin
                bist_mode  = 1'b1;
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_next = INIT;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bist_controller.sv
// Directed bench for bist_controller: an 8-pattern build with FLUSH_CYCLES=2 and
// a second build with FLUSH_CYCLES=0, both with GOLDEN=15'h1234.
module tb_bist_controller;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        start = 1'b0, start2 = 1'b0;
    logic        abort = 1'b0, abort2 = 1'b0;
    logic [14:0] misr_sig = 15'h0000;

    logic        tpg_rst, tpg_en, misr_rst, bist_end, bist_mode, busy, done, pass, fail;
    logic [15:0] pattern_cnt;
    logic        tpg_rst2, tpg_en2, misr_rst2, bist_end2, bist_mode2, busy2, done2, pass2, fail2;
    logic [15:0] pattern_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    bist_controller #(
        .N_PATTERNS(8), .CNT_W(16), .FLUSH_CYCLES(2), .SIG_W(15), .GOLDEN(15'h1234)
    ) dut (
        .CLK(CLK), .RST(RST), .start(start), .abort(abort), .misr_sig(misr_sig),
        .tpg_rst(tpg_rst), .tpg_en(tpg_en), .misr_rst(misr_rst), .bist_end(bist_end),
        .bist_mode(bist_mode), .busy(busy), .done(done), .pass(pass), .fail(fail),
        .pattern_cnt(pattern_cnt)
    );

    bist_controller #(
        .N_PATTERNS(8), .CNT_W(16), .FLUSH_CYCLES(0), .SIG_W(15), .GOLDEN(15'h1234)
    ) dut2 (
        .CLK(CLK), .RST(RST), .start(start2), .abort(abort2), .misr_sig(misr_sig),
        .tpg_rst(tpg_rst2), .tpg_en(tpg_en2), .misr_rst(misr_rst2), .bist_end(bist_end2),
        .bist_mode(bist_mode2), .busy(busy2), .done(done2), .pass(pass2), .fail(fail2),
        .pattern_cnt(pattern_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launches one session on dut (sel=0) or dut2 (sel=1) and tallies output activity
    // per cycle; j counts observations after the start edge (j=0 is the first INIT cycle).
    task automatic session(input bit sel, input logic [14:0] sig,
                           output int n_mrst, output int n_ten, output int n_bend0,
                           output int done_at, output logic [1:0] init_pf,
                           output int n_bad);
        n_mrst = 0; n_ten = 0; n_bend0 = 0; done_at = -1; init_pf = 2'b11; n_bad = 0;
        misr_sig = sig;
        if (sel) start2 = 1'b1; else start = 1'b1;
        for (int j = 0; j < 30; j++) begin
            @(negedge CLK);
            start  = 1'b0;
            start2 = 1'b0;
            if (j == 0) init_pf = sel ? {pass2, fail2} : {pass, fail};
            if (sel ? misr_rst2 : misr_rst)          n_mrst++;
            if (sel ? tpg_en2 : tpg_en)              n_ten++;
            if (!(sel ? bist_end2 : bist_end))       n_bend0++;
            if ((sel ? misr_rst2 : misr_rst) && !(sel ? bist_end2 : bist_end)) n_bad++;
            if (sel ? done2 : done) begin
                done_at = j;
                break;
            end
        end
    endtask

    int          n_mrst, n_ten, n_bend0, done_at, n_bad, done_seen;
    logic [1:0]  init_pf;

    initial begin
        // Reset and idle
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("idle_outs", {tpg_rst, tpg_en, misr_rst, bist_end, bist_mode, busy, done, pass, fail}, 9'b000100000);
        chk("idle_cnt", pattern_cnt, 0);
        chk("idle2_outs", {tpg_rst2, tpg_en2, misr_rst2, bist_end2, bist_mode2, busy2, done2, pass2, fail2}, 9'b000100000);

        // Pass path
        session(1'b0, 15'h1234, n_mrst, n_ten, n_bend0, done_at, init_pf, n_bad);
        chk("pass_misr_rst_cycles", n_mrst, 2);
        chk("pass_tpg_en_cycles", n_ten, 8);
        chk("pass_bist_end0_cycles", n_bend0, 10);
        chk("pass_done_at", done_at, 13);
        chk("pass_pf", {pass, fail}, 2'b10);
        chk("pass_cnt", pattern_cnt, 8);
        chk("pass_rst_vs_end", n_bad, 0);
        chk("done_outs", {busy, bist_mode, bist_end, tpg_en}, 4'b0010);

        // Fail path, then rerun from DONE
        session(1'b0, 15'h1235, n_mrst, n_ten, n_bend0, done_at, init_pf, n_bad);
        chk("fail_done_at", done_at, 13);
        chk("fail_pf", {pass, fail}, 2'b01);
        session(1'b0, 15'h1234, n_mrst, n_ten, n_bend0, done_at, init_pf, n_bad);
        chk("rerun_init_pf", init_pf, 2'b00);
        chk("rerun_pf", {pass, fail}, 2'b10);
        chk("rerun_cnt", pattern_cnt, 8);

        // Abort ignored in DONE; start beats abort
        abort = 1'b1;
        @(negedge CLK);
        chk("done_abort_ignored", {done, pass}, 2'b11);
        start = 1'b1;
        @(negedge CLK);
        chk("start_wins", {busy, misr_rst, pass}, 3'b110);
        start = 1'b0;
        abort = 1'b0;
        repeat (5) @(negedge CLK);
        chk("run4_state", {tpg_en, pattern_cnt}, {1'b1, 16'd3});
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        chk("abort_cnt", pattern_cnt, 4);
        chk("abort_outs", {pass, fail, bist_end, busy, tpg_en, done}, 6'b001000);
        @(negedge CLK);
        chk("abort_stays_idle", {busy, done}, 2'b00);

        // Reset in the middle of FLUSH
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (10) @(negedge CLK);
        chk("flush_outs", {bist_end, tpg_en, busy, pattern_cnt}, {3'b001, 16'd8});
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        chk("rst_flush_cnt", pattern_cnt, 0);
        chk("rst_flush_outs", {busy, done, bist_end}, 3'b001);
        done_seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge CLK);
            if (done) done_seen++;
        end
        chk("rst_no_done", done_seen, 0);
        session(1'b0, 15'h1234, n_mrst, n_ten, n_bend0, done_at, init_pf, n_bad);
        chk("post_rst_done_at", done_at, 13);
        chk("post_rst_tpg_en", n_ten, 8);
        chk("post_rst_pf_cnt", {pass, fail, pattern_cnt}, {2'b10, 16'd8});

        // FLUSH_CYCLES=0 build
        session(1'b1, 15'h1234, n_mrst, n_ten, n_bend0, done_at, init_pf, n_bad);
        chk("nf_done_at", done_at, 11);
        chk("nf_bist_end0_cycles", n_bend0, 8);
        chk("nf_tpg_en_cycles", n_ten, 8);
        chk("nf_pf_cnt", {pass2, fail2, pattern_cnt2}, {2'b10, 16'd8});
        chk("nf_other_idle", {busy, done}, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
